dma_burst_splitter: RTL and testbench

Read-side burst generator for the cluster DMA path. Accepts one 1D transfer descriptor (byte address, byte length) and emits a sequence of AXI INCR read bursts on the AR channel toward the SoC bus. Each burst is at most `MAX_BURST_BYTES` long and never crosses a `MAX_BURST_BYTES` or 4 KiB boundary. It also bounds the number of in-flight bursts by tracking completed R bursts. It sits directly upstream of the cluster AXI master port, between the DMA frontend and the `req_mst_t` AR channel.

---
 rtl/dma_split_pkg.sv | 27 ++
 rtl/dma_txn_counter.sv | 44 ++++
 rtl/dma_burst_splitter.sv | 216 +++++++++++++++++++++
 tb/tb_dma_burst_splitter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_split_pkg.sv
// Shared types and cluster-level defaults for the DMA read burst splitter.
package dma_split_pkg;

    // Cluster configuration defaults the splitter parameters derive from.
    localparam int unsigned CLUSTER_AXI_AW     = 32;
    localparam int unsigned CLUSTER_AXI_DW     = 64;
    localparam int unsigned CLUSTER_AXI_IW     = 6;
    localparam int unsigned DMA_MAX_BURST_SIZE = 2048;
    localparam int unsigned DMA_MAX_N_TXNS     = 64;

    // Bytes per data beat at the cluster default data width.
    localparam int unsigned BEAT_BYTES = CLUSTER_AXI_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } split_state_e;

    // 1D transfer descriptor as presented by the DMA frontend.
    typedef struct packed {
        logic [CLUSTER_AXI_AW-1:0] addr;
        logic [31:0]               len;
        logic [CLUSTER_AXI_IW-1:0] id;
    } dma_desc_t;

endpackage

// File: rtl/dma_txn_counter.sv
// Saturating up/down counter of outstanding read bursts with full/empty flags.
module dma_txn_counter #(
    parameter int unsigned MAX_TXNS = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic full_nxt_c
);

    localparam int unsigned CW = $clog2(MAX_TXNS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Simultaneous inc/dec cancel; decrement at zero and increment at max are ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CW'(MAX_TXNS))) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign full_nxt_c = (cnt_d == CW'(MAX_TXNS));

    // Count register with registered flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_o  <= full_nxt_c;
            empty_o <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/dma_burst_splitter.sv
// Splits a 1D read descriptor into AXI INCR AR bursts that never cross a
// MAX_BURST_BYTES boundary, bounding in-flight bursts to MAX_TXNS.
// Optional statistics counters: define DMA_BURST_STATS_EN.
module dma_burst_splitter #(
    parameter int unsigned AXI_AW          = dma_split_pkg::CLUSTER_AXI_AW,
    parameter int unsigned AXI_DW          = dma_split_pkg::CLUSTER_AXI_DW,
    parameter int unsigned AXI_IW          = dma_split_pkg::CLUSTER_AXI_IW,
    parameter int unsigned MAX_BURST_BYTES = dma_split_pkg::DMA_MAX_BURST_SIZE,
    parameter int unsigned MAX_TXNS        = dma_split_pkg::DMA_MAX_N_TXNS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AXI_AW-1:0] req_addr_i,
    input  logic [31:0]       req_len_i,
    input  logic [AXI_IW-1:0] req_id_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [AXI_AW-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    output logic [2:0]        ar_size_o,
    output logic [1:0]        ar_burst_o,
    output logic [AXI_IW-1:0] ar_id_o,
    input  logic              r_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       stat_bursts_o,
    output logic [31:0]       stat_stalls_o
);

    import dma_split_pkg::*;

    localparam int unsigned BEAT_B   = AXI_DW / 8;
    localparam int unsigned BEAT_LSB = $clog2(BEAT_B);

    // Bytes of the next burst: up to the next MAX_BURST_BYTES boundary, capped by what remains.
    function automatic logic [31:0] burst_bytes(input logic [AXI_AW-1:0] a,
                                                input logic [31:0]       rem);
        logic [31:0] room;
        room = 32'(MAX_BURST_BYTES) - 32'(a & AXI_AW'(MAX_BURST_BYTES - 1));
        return (rem < room) ? rem : room;
    endfunction

    // AXI length field (beats - 1); an empty burst encodes as 0.
    function automatic logic [7:0] beats_m1(input logic [31:0] bytes);
        logic [31:0] beats;
        beats = bytes >> BEAT_LSB;
        return (beats == 32'd0) ? 8'd0 : 8'(beats - 32'd1);
    endfunction

    split_state_e      state_q, state_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [31:0]       rem_q, rem_d;
    logic [AXI_IW-1:0] id_q, id_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic              ar_valid_q, ar_valid_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ar_hs_c;
    logic              misaligned_c;
    logic [31:0]       bytes_c;
    logic              cnt_full;
    logic              cnt_empty;
    logic              cnt_full_nxt_c;

    assign ar_hs_c      = ar_valid_q && ar_ready_i;
    assign bytes_c      = burst_bytes(addr_q, rem_q);
    assign misaligned_c = ((req_addr_i & AXI_AW'(BEAT_B - 1)) != '0) ||
                          ((req_len_i  & 32'(BEAT_B - 1))     != 32'd0);

    dma_txn_counter #(
        .MAX_TXNS (MAX_TXNS)
    ) u_txn_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (ar_hs_c),
        .dec_i      (r_done_i),
        .full_o     (cnt_full),
        .empty_o    (cnt_empty),
        .full_nxt_c (cnt_full_nxt_c)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !misaligned_c && (req_len_i != 32'd0)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs_c && (rem_q == bytes_c)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the descriptor walk and registered outputs.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        id_d   = id_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (misaligned_c) begin
                        err_d = 1'b1;
                    end else if (req_len_i == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d = req_addr_i;
                        rem_d  = req_len_i;
                        id_d   = req_id_i;
                    end
                end
            end
            ST_ISSUE: begin
                if (ar_hs_c) begin
                    addr_d = addr_q + AXI_AW'(bytes_c);
                    rem_d  = rem_q - bytes_c;
                end
            end
            ST_DRAIN: begin
                done_d = cnt_empty;
            end
            default: ;
        endcase
        // Valid only drops via a handshake that fills the counter, so it is never withdrawn early.
        ar_valid_d = (state_d == ST_ISSUE) && !cnt_full_nxt_c;
        ar_len_d   = beats_m1(burst_bytes(addr_d, rem_d));
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            rem_q      <= '0;
            id_q       <= '0;
            ar_len_q   <= '0;
            ar_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            id_q       <= id_d;
            ar_len_q   <= ar_len_d;
            ar_valid_q <= ar_valid_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign ar_valid_o  = ar_valid_q;
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = ar_len_q;
    assign ar_id_o     = id_q;
    assign ar_size_o   = 3'(BEAT_LSB);
    assign ar_burst_o  = 2'b01;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef DMA_BURST_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_stalls_q;

    // Free-running, wrapping handshake and outstanding-limit stall counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_bursts_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (ar_hs_c) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
            if ((state_q == ST_ISSUE) && cnt_full) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_bursts_o = stat_bursts_q;
    assign stat_stalls_o = stat_stalls_q;
`else
    assign stat_bursts_o = 32'd0;
    assign stat_stalls_o = 32'd0;
`endif

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Directed bench for dma_burst_splitter (instance limited to 2 outstanding bursts).
module tb_dma_burst_splitter;

`ifdef DMA_BURST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_len;
    logic [5:0]  req_id;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_id;
    logic        r_done;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] stat_bursts;
    logic [31:0] stat_stalls;

    int total = 0;
    int bad   = 0;
    int exp_bursts = 0;
    int exp_stalls = 0;

    dma_burst_splitter #(
        .MAX_TXNS (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_len_i     (req_len),
        .req_id_i      (req_id),
        .ar_valid_o    (ar_valid),
        .ar_ready_i    (ar_ready),
        .ar_addr_o     (ar_addr),
        .ar_len_o      (ar_len),
        .ar_size_o     (ar_size),
        .ar_burst_o    (ar_burst),
        .ar_id_o       (ar_id),
        .r_done_i      (r_done),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .stat_bursts_o (stat_bursts),
        .stat_stalls_o (stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [5:0]  id;
        bit          exp_err;
        int          nb;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] a1;
        logic [7:0]  l1;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ar(input string tag, input logic [31:0] a, input logic [7:0] l,
                            input logic [5:0] id);
        chk({tag, "_valid"}, 64'(ar_valid), 64'd1);
        chk({tag, "_addr"},  64'(ar_addr),  64'(a));
        chk({tag, "_len"},   64'(ar_len),   64'(l));
        chk({tag, "_id"},    64'(ar_id),    64'(id));
        chk({tag, "_size"},  64'(ar_size),  64'd3);
        chk({tag, "_burst"}, 64'(ar_burst), 64'd1);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_stat_bursts"}, 64'(stat_bursts), STATS ? 64'(exp_bursts) : 64'd0);
        chk({tag, "_stat_stalls"}, 64'(stat_stalls), STATS ? 64'(exp_stalls) : 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_ar_valid"},  64'(ar_valid),  64'd0);
        chk({tag, "_ar_addr"},   64'(ar_addr),   64'd0);
        chk({tag, "_ar_len"},    64'(ar_len),    64'd0);
        chk({tag, "_ar_id"},     64'(ar_id),     64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_err"},       64'(err),       64'd0);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] l, input logic [5:0] id);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_id    = id;
        tick();
        req_valid = 1'b0;
    endtask

    // One table record: accept, follow the bursts, complete them, check done timing.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        ar_ready = 1'b1;
        accept(v.addr, v.len, v.id);
        if (v.exp_err) begin
            chk({tag, "_err_pulse"}, 64'(err), 64'd1);
            chk({tag, "_no_done"},   64'(done), 64'd0);
            chk({tag, "_no_ar"},     64'(ar_valid), 64'd0);
            chk({tag, "_not_busy"},  64'(busy), 64'd0);
            tick();
            chk({tag, "_err_end"},   64'(err), 64'd0);
            chk({tag, "_no_ar2"},    64'(ar_valid), 64'd0);
        end else if (v.nb == 0) begin
            chk({tag, "_done_pulse"}, 64'(done), 64'd1);
            chk({tag, "_no_err"},     64'(err), 64'd0);
            chk({tag, "_no_ar"},      64'(ar_valid), 64'd0);
            chk({tag, "_not_busy"},   64'(busy), 64'd0);
            tick();
            chk({tag, "_done_end"},   64'(done), 64'd0);
        end else begin
            for (int k = 0; k < v.nb; k++) begin
                check_ar($sformatf("%s_b%0d", tag, k), (k == 0) ? v.a0 : v.a1,
                         (k == 0) ? v.l0 : v.l1, v.id);
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                tick();
            end
            exp_bursts += v.nb;
            chk({tag, "_ar_idle"},   64'(ar_valid), 64'd0);
            chk({tag, "_drain_busy"}, 64'(busy), 64'd1);
            r_done = 1'b1;
            repeat (v.nb) tick();
            r_done = 1'b0;
            // Counter reads zero now; done follows one cycle later.
            chk({tag, "_done_early"}, 64'(done), 64'd0);
            tick();
            chk({tag, "_done_pulse"}, 64'(done), 64'd1);
            chk({tag, "_idle_busy"},  64'(busy), 64'd0);
            tick();
            chk({tag, "_done_end"},   64'(done), 64'd0);
        end
        check_stats(tag);
    endtask

    initial begin
        vecs[0] = '{32'h1000_07F0, 32'h40,   6'd1, 1'b0, 2, 32'h1000_07F0, 8'd1,   32'h1000_0800, 8'd5};
        vecs[1] = '{32'h0000_0000, 32'd4096, 6'd2, 1'b0, 2, 32'h0000_0000, 8'd255, 32'h0000_0800, 8'd255};
        vecs[2] = '{32'h0000_0004, 32'd16,   6'd3, 1'b1, 0, 32'h0,         8'd0,   32'h0,         8'd0};
        vecs[3] = '{32'h0000_0008, 32'd0,    6'd4, 1'b0, 0, 32'h0,         8'd0,   32'h0,         8'd0};
        vecs[4] = '{32'h0000_0FF8, 32'h10,   6'd5, 1'b0, 2, 32'h0000_0FF8, 8'd0,   32'h0000_1000, 8'd0};
        vecs[5] = '{32'h0000_0100, 32'h8,    6'd6, 1'b0, 1, 32'h0000_0100, 8'd0,   32'h0,         8'd0};
        vecs[6] = '{32'h0000_0010, 32'hC,    6'd7, 1'b1, 0, 32'h0,         8'd0,   32'h0,         8'd0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_id    = '0;
        ar_ready  = 1'b1;
        r_done    = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        chk("reset_size",  64'(ar_size),  64'd3);
        chk("reset_burst", 64'(ar_burst), 64'd1);
        check_stats("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Outstanding limit of 2: third and fourth bursts wait for completions.
        ar_ready = 1'b1;
        accept(32'h0, 32'd8192, 6'd5);
        check_ar("lim_b0", 32'h0000, 8'd255, 6'd5);
        tick();
        check_ar("lim_b1", 32'h0800, 8'd255, 6'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("lim_hold_valid", 64'(ar_valid), 64'd0);
            chk("lim_hold_addr",  64'(ar_addr),  64'h1000);
            chk("lim_hold_len",   64'(ar_len),   64'd255);
            chk("lim_hold_busy",  64'(busy),     64'd1);
            if (i < 3) tick();
        end
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        check_ar("lim_b2", 32'h1000, 8'd255, 6'd5);
        tick();
        chk("lim_hold2_valid", 64'(ar_valid), 64'd0);
        chk("lim_hold2_addr",  64'(ar_addr),  64'h1800);
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        check_ar("lim_b3", 32'h1800, 8'd255, 6'd5);
        exp_stalls = 5;
        chk("lim_stat_stalls", 64'(stat_stalls), STATS ? 64'd5 : 64'd0);
        tick();
        chk("lim_drain_valid", 64'(ar_valid), 64'd0);
        chk("lim_drain_busy",  64'(busy),     64'd1);
        r_done = 1'b1;
        tick();
        tick();
        r_done = 1'b0;
        chk("lim_done_early", 64'(done), 64'd0);
        tick();
        chk("lim_done_pulse", 64'(done), 64'd1);
        exp_bursts += 4;
        check_stats("lim");
        tick();

        // AR backpressure for 5 cycles; completion coincides with the handshake.
        ar_ready = 1'b1;
        accept(32'h0, 32'd4096, 6'd7);
        check_ar("bp_b0", 32'h0000, 8'd255, 6'd7);
        tick();
        ar_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_ar("bp_hold", 32'h0800, 8'd255, 6'd7);
            if (i == 5) begin
                ar_ready = 1'b1;
                r_done   = 1'b1;
            end
            tick();
        end
        r_done = 1'b0;
        chk("bp_drain_valid", 64'(ar_valid), 64'd0);
        chk("bp_drain_busy",  64'(busy),     64'd1);
        tick();
        // One burst is still outstanding, so no completion yet.
        chk("bp_still_busy", 64'(busy), 64'd1);
        chk("bp_no_done",    64'(done), 64'd0);
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        chk("bp_done_early", 64'(done), 64'd0);
        tick();
        chk("bp_done_pulse", 64'(done), 64'd1);
        exp_bursts += 2;
        check_stats("bp");
        tick();

        // Reset in the middle of a 4-burst transfer.
        accept(32'h0, 32'h2000, 6'd9);
        check_ar("rst_b0", 32'h0000, 8'd255, 6'd9);
        tick();
        check_ar("rst_b1", 32'h0800, 8'd255, 6'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        exp_bursts = 0;
        exp_stalls = 0;
        check_stats("midrst");
        tick();
        chk("midrst_no_done",  64'(done),     64'd0);
        chk("midrst_no_valid", 64'(ar_valid), 64'd0);
        run_vec(10, vecs[0]);
        run_vec(11, vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
